coef_ram_arbiter: RTL and testbench
===================================

Name: coef_ram_arbiter

Overview:
- Arbitrates one single-port, synchronous-read coefficient RAM between two requesters:
  - Host writes, decoded from SPI register writes (EQ/tap select plus data).
  - FIR engine tap reads.
- FIR reads have priority. Host writes are buffered in a small FIFO and drained in FIR-idle cycles.
- A starvation guard forces a drain slot when the FIFO stays full.
- Sits between the SPI register block and the FIR datapath; replaces direct per-tap coefficient registers.

Parameters:
- NUM_EQ, 4, number of equalizer filters; valid eq index 0..NUM_EQ-1.
- TAPS, 64, taps per filter; valid tap index 0..TAPS-1.
- EQ_BITS, 2, RAM address bits for eq (clog2 NUM_EQ).
- TAP_BITS, 6, RAM address bits for tap (clog2 TAPS).
- FIFO_DEPTH, 4, pending host-write entries (power of 2).
- STARVE_LIMIT, 8, consecutive full-FIFO-and-FIR-busy cycles before a forced write slot.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- host_wr_stb  in  1  one-cycle coefficient write request
- host_eq  in  6  eq select (eq_tap_sel bits 15:10)
- host_tap  in  10  tap select (eq_tap_sel bits 9:0)
- host_wr_data  in  16  coefficient value
- host_sel_stb  in  1  one-cycle pulse: load auto-increment pointer (feature only; ignored otherwise)
- clr_err  in  1  clears sticky error flags
- fir_rd_req  in  1  FIR tap read request, level
- fir_rd_eq  in  EQ_BITS  FIR eq index
- fir_rd_tap  in  TAP_BITS  FIR tap index
- fir_rd_gnt  out  1  request accepted this cycle (combinational)
- fir_rd_valid  out  1  read data valid, one cycle after grant
- fir_rd_data  out  16  coefficient
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  EQ_BITS+TAP_BITS  address = {eq, tap}
- ram_wdata  out  16  write data
- ram_rdata  in  16  RAM read data, valid one cycle after ram_en with ram_we=0
- pending  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- busy  out  1  pending != 0
- ovf_err  out  1  sticky: host write dropped, FIFO full
- range_err  out  1  sticky: host write dropped, index out of range

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - FIFO emptied; pending writes discarded.
  - pending=0, busy=0, ovf_err=0, range_err=0.
  - fir_rd_valid=0, fir_rd_data=0, starve counter=0, pointer=0.
  - ram_en/ram_we deasserted.
- Host push, on host_wr_stb:
  - If eq>=NUM_EQ or tap>=TAPS: dropped, range_err<=1.
  - Else if pending==FIFO_DEPTH and no pop this cycle: dropped, ovf_err<=1.
  - Otherwise pushed; visible in pending next cycle.
  - Push and pop in the same cycle leave pending unchanged.
- Arbitration, per cycle, one RAM access max:
  - FORCE: starve_cnt==STARVE_LIMIT and FIFO non-empty → pop, write RAM. fir_rd_gnt=0; FIR holds its request. starve_cnt<=0.
  - FIR: else if fir_rd_req → fir_rd_gnt=1; ram_en=1, ram_we=0, ram_addr={fir_rd_eq,fir_rd_tap}.
  - DRAIN: else if FIFO non-empty → pop head; ram_en=1, ram_we=1, addr/data from head.
  - IDLE: ram_en=0.
- Starve counter:
  - Increments when FIFO is full and FIR wins.
  - Resets to 0 otherwise.
  - Saturates at STARVE_LIMIT.
- Read latency: fir_rd_valid=1 exactly one cycle after fir_rd_gnt; fir_rd_data registered from ram_rdata then; otherwise fir_rd_valid=0 and data holds its last value.
- Writes complete in FIFO order. A FIR read of an address with a pending write returns the old RAM value; no forwarding.
- clr_err clears both sticky flags. If a clear and a new error occur in the same cycle, the error wins.

Optional Feature:
- Macro COEF_AUTOINC_EN.
- Defined:
  - host_sel_stb loads an internal {eq,tap} pointer from host_eq/host_tap.
  - host_wr_stb uses the pointer instead of host_eq/host_tap.
  - After each accepted push, tap increments; TAPS-1 wraps to 0 with eq+1; eq NUM_EQ-1 wraps to 0.
  - Range check is applied at pointer load; an out-of-range load sets range_err and leaves the pointer unchanged.
  - Simultaneous host_sel_stb and host_wr_stb: the load happens first, then the write uses the new pointer.
- Undefined: host_sel_stb ignored; address taken directly from the ports.

Decomposition:
- Package coef_ram_pkg holds:
  - COEF_W=16, HOST_EQ_W=6, HOST_TAP_W=10.
  - Arbitration grant enum {G_IDLE, G_FIR, G_DRAIN, G_FORCE}.
  - A pack-address function {eq,tap}.
- Sub-module coef_wr_fifo: synchronous FIFO of {addr,data}, with push/pop/full/empty/count.

Test Plan:
- Reset, then host_wr_stb eq=1 tap=5 data=16'h1234 with FIR idle → pending 1, then next cycle ram_we=1 addr=8'h45 wdata=16'h1234, pending 0; a later FIR read of eq1/tap5 → fir_rd_valid one cycle after grant, data 16'h1234.
- fir_rd_req held high, 5 host writes back-to-back → first 4 queued, 5th dropped, ovf_err=1; after 8 full cycles a FORCE slot occurs: fir_rd_gnt=0 for one cycle, one write drained.
- host_wr_stb eq=4 (NUM_EQ=4) or tap=64 → no push, range_err=1; clr_err → 0.
- FIFO full with host push in the same cycle as DRAIN pop → push accepted, pending stays 4, ovf_err stays 0.
- Assert reset_n=0 with 3 pending writes → pending 0, no RAM writes after reset, flags 0.
- With COEF_AUTOINC_EN: host_sel_stb eq=0 tap=62, then 3 writes → addresses {0,62}, {0,63}, {1,0}.

Source files
------------

// File: rtl/coef_ram_pkg.sv
// Shared types and constants for the coefficient RAM arbiter.
package coef_ram_pkg;

  localparam int COEF_W       = 16;
  localparam int HOST_EQ_W    = 6;
  localparam int HOST_TAP_W   = 10;
  localparam int RAM_EQ_BITS  = 2;
  localparam int RAM_TAP_BITS = 6;
  localparam int RAM_ADDR_W   = RAM_EQ_BITS + RAM_TAP_BITS;

  typedef enum logic [1:0] {G_IDLE, G_FIR, G_DRAIN, G_FORCE} grant_e;

  function automatic logic [RAM_ADDR_W-1:0] pack_addr(input logic [RAM_EQ_BITS-1:0]  eq,
                                                      input logic [RAM_TAP_BITS-1:0] tap);
    return {eq, tap};
  endfunction

endpackage

// File: rtl/coef_wr_fifo.sv
// Small synchronous FIFO holding pending host coefficient writes ({addr, data}).
module coef_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/coef_ram_arbiter.sv
// Shares one single-port coefficient RAM between FIR tap reads (priority) and
// buffered host writes. Optional macro COEF_AUTOINC_EN enables an auto-incrementing write pointer.
module coef_ram_arbiter
  import coef_ram_pkg::*;
#(
  parameter int NUM_EQ       = 4,
  parameter int TAPS         = 64,
  parameter int EQ_BITS      = RAM_EQ_BITS,
  parameter int TAP_BITS     = RAM_TAP_BITS,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         host_wr_stb,
  input  logic [HOST_EQ_W-1:0]         host_eq,
  input  logic [HOST_TAP_W-1:0]        host_tap,
  input  logic [COEF_W-1:0]            host_wr_data,
  input  logic                         host_sel_stb,
  input  logic                         clr_err,
  input  logic                         fir_rd_req,
  input  logic [EQ_BITS-1:0]           fir_rd_eq,
  input  logic [TAP_BITS-1:0]          fir_rd_tap,
  output logic                         fir_rd_gnt,
  output logic                         fir_rd_valid,
  output logic [COEF_W-1:0]            fir_rd_data,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [EQ_BITS+TAP_BITS-1:0]  ram_addr,
  output logic [COEF_W-1:0]            ram_wdata,
  input  logic [COEF_W-1:0]            ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]  pending,
  output logic                         busy,
  output logic                         ovf_err,
  output logic                         range_err
);

  localparam int ADDR_W  = EQ_BITS + TAP_BITS;
  localparam int ENTRY_W = ADDR_W + COEF_W;
  localparam int SC_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [HOST_EQ_W-1:0]  EQ_LIM  = HOST_EQ_W'(NUM_EQ);
  localparam logic [HOST_TAP_W-1:0] TAP_LIM = HOST_TAP_W'(TAPS);

  grant_e              w_grant;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [ENTRY_W-1:0]  w_head;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [COEF_W-1:0]   w_head_data;
  logic [ADDR_W-1:0]   w_fir_addr;
  logic [EQ_BITS-1:0]  w_wr_eq;
  logic [TAP_BITS-1:0] w_wr_tap;
  logic                w_wr_in_range;
  logic                w_range_set;
  logic                w_ovf_set;

  logic [SC_W-1:0]     r_starve;
  logic                r_ovf;
  logic                r_rng;
  logic                r_rd_valid;
  logic [COEF_W-1:0]   r_rd_hold;

`ifdef COEF_AUTOINC_EN
  logic [EQ_BITS-1:0]  r_ptr_eq;
  logic [TAP_BITS-1:0] r_ptr_tap;
  logic                w_sel_ok;

  // A same-cycle pointer load takes effect before the write uses the address.
  assign w_sel_ok      = (host_eq < EQ_LIM) && (host_tap < TAP_LIM);
  assign w_wr_eq       = (host_sel_stb && w_sel_ok) ? host_eq[EQ_BITS-1:0]   : r_ptr_eq;
  assign w_wr_tap      = (host_sel_stb && w_sel_ok) ? host_tap[TAP_BITS-1:0] : r_ptr_tap;
  assign w_wr_in_range = 1'b1;
  assign w_range_set   = host_sel_stb && !w_sel_ok;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr_eq  <= '0;
      r_ptr_tap <= '0;
    end else if (w_push) begin
      if (w_wr_tap == TAP_BITS'(TAPS - 1)) begin
        r_ptr_tap <= '0;
        r_ptr_eq  <= (w_wr_eq == EQ_BITS'(NUM_EQ - 1)) ? '0 : w_wr_eq + EQ_BITS'(1);
      end else begin
        r_ptr_tap <= w_wr_tap + TAP_BITS'(1);
        r_ptr_eq  <= w_wr_eq;
      end
    end else if (host_sel_stb && w_sel_ok) begin
      r_ptr_eq  <= host_eq[EQ_BITS-1:0];
      r_ptr_tap <= host_tap[TAP_BITS-1:0];
    end
  end
`else
  logic w_unused_sel;

  assign w_unused_sel  = host_sel_stb;
  assign w_wr_eq       = host_eq[EQ_BITS-1:0];
  assign w_wr_tap      = host_tap[TAP_BITS-1:0];
  assign w_wr_in_range = (host_eq < EQ_LIM) && (host_tap < TAP_LIM);
  assign w_range_set   = reset_n && host_wr_stb && !w_wr_in_range;
`endif

  coef_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata ({pack_addr(w_wr_eq, w_wr_tap), host_wr_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (pending)
  );

  assign w_head_addr = w_head[ENTRY_W-1:COEF_W];
  assign w_head_data = w_head[COEF_W-1:0];
  assign w_fir_addr  = pack_addr(fir_rd_eq, fir_rd_tap);

  // Forced drain slot beats the FIR once the FIFO has been starved long enough.
  always_comb begin
    w_grant = G_IDLE;
    if (!reset_n)
      w_grant = G_IDLE;
    else if ((r_starve == SC_W'(STARVE_LIMIT)) && !w_empty)
      w_grant = G_FORCE;
    else if (fir_rd_req)
      w_grant = G_FIR;
    else if (!w_empty)
      w_grant = G_DRAIN;
  end

  assign w_pop     = (w_grant == G_DRAIN) || (w_grant == G_FORCE);
  assign w_push    = reset_n && host_wr_stb && w_wr_in_range && (!w_full || w_pop);
  assign w_ovf_set = reset_n && host_wr_stb && w_wr_in_range && w_full && !w_pop;

  always_comb begin
    fir_rd_gnt = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = w_head_addr;
    ram_wdata  = w_head_data;
    unique case (w_grant)
      G_FIR: begin
        fir_rd_gnt = 1'b1;
        ram_en     = 1'b1;
        ram_addr   = w_fir_addr;
      end
      G_DRAIN, G_FORCE: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_starve   <= '0;
      r_ovf      <= 1'b0;
      r_rng      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_hold  <= '0;
    end else begin
      if (w_full && (w_grant == G_FIR))
        r_starve <= (r_starve == SC_W'(STARVE_LIMIT)) ? r_starve : r_starve + SC_W'(1);
      else
        r_starve <= '0;
      r_ovf      <= w_ovf_set   | (r_ovf & ~clr_err);
      r_rng      <= w_range_set | (r_rng & ~clr_err);
      r_rd_valid <= (w_grant == G_FIR);
      if (r_rd_valid) r_rd_hold <= ram_rdata;
    end
  end

  // RAM data passes straight through in the valid cycle and is held afterwards.
  assign fir_rd_valid = r_rd_valid;
  assign fir_rd_data  = r_rd_valid ? ram_rdata : r_rd_hold;
  assign busy         = (pending != '0);
  assign ovf_err      = r_ovf;
  assign range_err    = r_rng;

endmodule

// File: tb/tb_coef_ram_arbiter.sv
// Randomized and directed bench for coef_ram_arbiter against a queue-based reference model.
module tb_coef_ram_arbiter;

  localparam int NUM_EQ = 4;
  localparam int TAPS   = 64;
  localparam int DEPTH  = 4;
  localparam int SLIMIT = 8;
  localparam int NADDR  = NUM_EQ * TAPS;
`ifdef COEF_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int M_IDLE = 0, M_FIR = 1, M_WRITE = 2, M_FORCE = 3;

  logic        clk = 1'b0;
  logic        reset_n, host_wr_stb, host_sel_stb, clr_err, fir_rd_req;
  logic [5:0]  host_eq;
  logic [9:0]  host_tap;
  logic [15:0] host_wr_data;
  logic [1:0]  fir_rd_eq;
  logic [5:0]  fir_rd_tap;
  logic        fir_rd_gnt, fir_rd_valid, ram_en, ram_we, busy, ovf_err, range_err;
  logic [15:0] fir_rd_data, ram_wdata, env_rdata;
  logic [7:0]  ram_addr;
  logic [2:0]  pending;

  always #5 clk = ~clk;

  coef_ram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .host_wr_stb(host_wr_stb), .host_eq(host_eq),
    .host_tap(host_tap), .host_wr_data(host_wr_data), .host_sel_stb(host_sel_stb),
    .clr_err(clr_err), .fir_rd_req(fir_rd_req), .fir_rd_eq(fir_rd_eq),
    .fir_rd_tap(fir_rd_tap), .fir_rd_gnt(fir_rd_gnt), .fir_rd_valid(fir_rd_valid),
    .fir_rd_data(fir_rd_data), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(env_rdata), .pending(pending), .busy(busy),
    .ovf_err(ovf_err), .range_err(range_err)
  );

  // Behavioural single-port RAM with a synchronous read.
  function automatic logic [15:0] init_val(input int a);
    return 16'((a * 257) ^ 16'h3c3c);
  endfunction

  logic [15:0] env_mem [NADDR];
  bit          env_wr  [NADDR];
  always @(posedge clk) begin
    if (ram_en === 1'b1) begin
      if (ram_we) begin
        env_mem[ram_addr] <= ram_wdata;
        env_wr[ram_addr]  <= 1'b1;
      end else begin
        env_rdata <= env_wr[ram_addr] ? env_mem[ram_addr] : init_val(int'(ram_addr));
      end
    end
  end

  // Reference model state.
  typedef struct { int a; logic [15:0] d; } wr_t;
  wr_t         m_q[$];
  logic [15:0] m_mem [NADDR];
  int          m_starve, m_ptr;
  bit          m_ok, m_ovf, m_rng, m_valid;
  logic [15:0] m_data;

  int n_chk = 0, n_pass = 0;

  bit          s_rst_n, s_wr, s_sel, s_clr, s_req;
  int          s_eq, s_tap, s_req_eq, s_req_tap;
  logic [15:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    int g, wa;
    bit full, popd, rset, oset, inr;
    @(negedge clk);
    reset_n = s_rst_n; host_wr_stb = s_wr; host_sel_stb = s_sel; clr_err = s_clr;
    host_eq = 6'(s_eq); host_tap = 10'(s_tap); host_wr_data = s_data;
    fir_rd_req = s_req; fir_rd_eq = 2'(s_req_eq); fir_rd_tap = 6'(s_req_tap);
    #1;
    if (!s_rst_n)                              g = M_IDLE;
    else if (m_starve == SLIMIT && m_q.size() > 0) g = M_FORCE;
    else if (s_req)                            g = M_FIR;
    else if (m_q.size() > 0)                   g = M_WRITE;
    else                                       g = M_IDLE;
    if (m_ok) begin
      chk("gnt", fir_rd_gnt, g == M_FIR);
      chk("ram_en", ram_en, g != M_IDLE);
      chk("ram_we", ram_we, g == M_WRITE || g == M_FORCE);
      if (g == M_FIR) chk("rd_addr", ram_addr, s_req_eq * TAPS + s_req_tap);
      if (g == M_WRITE || g == M_FORCE) begin
        chk("wr_addr", ram_addr, m_q[0].a);
        chk("wr_data", ram_wdata, m_q[0].d);
      end
      chk("pending", pending, m_q.size());
      chk("busy", busy, m_q.size() != 0);
      chk("ovf_err", ovf_err, m_ovf);
      chk("range_err", range_err, m_rng);
      chk("rd_valid", fir_rd_valid, m_valid);
      chk("rd_data", fir_rd_data, m_data);
    end
    if (!s_rst_n) begin
      m_q.delete(); m_starve = 0; m_ptr = 0; m_ovf = 0; m_rng = 0;
      m_valid = 0; m_data = '0; m_ok = 1;
      return;
    end
    full = (m_q.size() == DEPTH);
    popd = (g == M_WRITE || g == M_FORCE);
    if (popd) begin
      m_mem[m_q[0].a] = m_q[0].d;
      void'(m_q.pop_front());
    end
    m_starve = (full && g == M_FIR) ? ((m_starve < SLIMIT) ? m_starve + 1 : SLIMIT) : 0;
    rset = 0; oset = 0;
    if (AUTOINC && s_sel) begin
      if (s_eq < NUM_EQ && s_tap < TAPS) m_ptr = s_eq * TAPS + s_tap;
      else rset = 1;
    end
    if (s_wr) begin
      wa  = AUTOINC ? m_ptr : s_eq * TAPS + s_tap;
      inr = AUTOINC ? 1'b1 : (s_eq < NUM_EQ && s_tap < TAPS);
      if (!inr) rset = 1;
      else if (full && !popd) oset = 1;
      else begin
        m_q.push_back('{a: wa, d: s_data});
        if (AUTOINC) m_ptr = (m_ptr + 1) % NADDR;
      end
    end
    m_ovf = oset | (m_ovf & !s_clr);
    m_rng = rset | (m_rng & !s_clr);
    m_valid = (g == M_FIR);
    if (m_valid) m_data = m_mem[s_req_eq * TAPS + s_req_tap];
  endtask

  task automatic quiet();
    s_rst_n = 1; s_wr = 0; s_sel = 0; s_clr = 0; s_req = 0;
    s_eq = 0; s_tap = 0; s_req_eq = 0; s_req_tap = 0; s_data = '0;
  endtask

  task automatic host_write(input int eq, input int tap, input logic [15:0] d);
    s_wr = 1; s_eq = eq; s_tap = tap; s_data = d;
    tick();
    s_wr = 0;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < NADDR; i++) m_mem[i] = init_val(i);
    m_ok = 0;
    quiet();
    s_rst_n = 0;
    reset_n = 0; host_wr_stb = 0; host_sel_stb = 0; clr_err = 0; fir_rd_req = 0;
    host_eq = '0; host_tap = '0; host_wr_data = '0; fir_rd_eq = '0; fir_rd_tap = '0;
    tick(); tick();
    chk("rst_pending", pending, 0);
    chk("rst_valid", fir_rd_valid, 0);
    chk("rst_data", fir_rd_data, 0);
    s_rst_n = 1;

    // Single write drained in an idle slot, then read back.
    host_write(1, 5, 16'h1234);
    tick();
    chk("t1_pend1", pending, 1);
    chk("t1_we", ram_we, 1);
    chk("t1_wdata", ram_wdata, 16'h1234);
`ifndef COEF_AUTOINC_EN
    chk("t1_addr", ram_addr, 8'h45);
`endif
    tick();
    chk("t1_pend0", pending, 0);
    s_req = 1; s_req_eq = 1; s_req_tap = 5;
    tick();
    chk("t1_gnt", fir_rd_gnt, 1);
    s_req = 0;
    tick();
    chk("t1_valid", fir_rd_valid, 1);
`ifndef COEF_AUTOINC_EN
    chk("t1_rdata", fir_rd_data, 16'h1234);
`endif

    // FIR hogs the RAM: overflow, then a forced drain slot.
    s_req = 1; s_req_eq = 2; s_req_tap = 9;
    for (int k = 0; k < 5; k++) host_write(2, k, 16'(16'ha000 + k));
    tick();
    chk("t2_ovf", ovf_err, 1);
    chk("t2_full", pending, 4);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (fir_rd_gnt === 1'b0) found = 1;
    end
    chk("t2_force_seen", found, 1);
    chk("t2_force_we", ram_we, 1);
    tick();
    chk("t2_after_force", pending, 3);
    s_req = 0;
    repeat (4) tick();
    chk("t2_drained", pending, 0);

    // Range errors and clear priority.
    s_clr = 1; tick(); s_clr = 0;
`ifndef COEF_AUTOINC_EN
    host_write(4, 0, 16'h1111);
    tick();
    chk("t3_rng_eq", range_err, 1);
    chk("t3_no_push", pending, 0);
    s_clr = 1; tick(); s_clr = 0;
    tick();
    chk("t3_clr", range_err, 0);
    host_write(0, 64, 16'h2222);
    tick();
    chk("t3_rng_tap", range_err, 1);
    s_clr = 1; host_write(3, 70, 16'h3333); s_clr = 0;
    tick();
    chk("t3_err_wins", range_err, 1);
`else
    s_sel = 1; s_eq = 4; s_tap = 0; tick(); s_sel = 0;
    tick();
    chk("t3_sel_rng", range_err, 1);
`endif
    s_clr = 1; tick(); s_clr = 0;

    // Push into a full FIFO while a drain pops.
    s_req = 1;
    for (int k = 0; k < 4; k++) host_write(3, 10 + k, 16'(16'hb000 + k));
    s_req = 0;
    host_write(3, 20, 16'hb0ff);
    s_req = 1;
    tick();
    chk("t4_pend", pending, 4);
    chk("t4_ovf", ovf_err, 0);
    s_req = 0;
    repeat (5) tick();

    // Reset with writes pending discards them.
    s_req = 1;
    for (int k = 0; k < 3; k++) host_write(0, 30 + k, 16'(16'hc000 + k));
    s_rst_n = 0; tick(); s_rst_n = 1; s_req = 0;
    tick();
    chk("t5_pend", pending, 0);
    chk("t5_we", ram_we, 0);
    chk("t5_flags", {ovf_err, range_err}, 0);
    tick();
    chk("t5_we2", ram_we, 0);

`ifdef COEF_AUTOINC_EN
    // Auto-increment across the tap/eq boundary.
    s_sel = 1; s_eq = 0; s_tap = 62; tick(); s_sel = 0;
    s_req = 1;
    for (int k = 0; k < 3; k++) host_write(0, 0, 16'(16'hd000 + k));
    s_req = 0;
    tick(); chk("t6_addr0", ram_addr, 8'd62);
    tick(); chk("t6_addr1", ram_addr, 8'd63);
    tick(); chk("t6_addr2", ram_addr, 8'h40);
`endif

    // Randomized traffic.
    begin
      bit hog;
      hog = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (cyc % 40 == 0) hog = ($urandom_range(0, 1) == 1);
        s_rst_n   = ($urandom_range(0, 299) != 0);
        s_req     = hog ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
        s_req_eq  = $urandom_range(0, NUM_EQ - 1);
        s_req_tap = $urandom_range(0, TAPS - 1);
        s_wr      = ($urandom_range(0, 9) < 4);
        s_sel     = ($urandom_range(0, 9) == 0);
        s_clr     = ($urandom_range(0, 19) == 0);
        s_data    = 16'($urandom);
        if ($urandom_range(0, 9) == 0) begin
          s_eq  = $urandom_range(0, 63);
          s_tap = (s_eq < NUM_EQ) ? $urandom_range(TAPS, 1023) : $urandom_range(0, 1023);
        end else begin
          s_eq  = $urandom_range(0, NUM_EQ - 1);
          s_tap = $urandom_range(0, TAPS - 1);
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
